// File: rtl/priority_arbiter.sv
// priority_arbiter
//   N-channel arbiter with a registered one-hot grant. In fixed mode the
//   highest requesting index wins. In round-robin mode the search starts at a
//   rotating pointer. A grant is held while its requester keeps asserting, up
//   to MAX_HOLD consecutive cycles. When that limit is reached the grant is
//   forcibly released and a one-cycle timeout pulse is issued. Every release
//   is followed by one idle turnaround cycle before the next grant.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        [N-1:0] request vector
//   mode       0 = fixed priority (highest index), 1 = round-robin
//   gnt        [N-1:0] registered one-hot grant, zero when idle
//   gnt_idx    [W-1:0] registered index of the granted channel, 0 when idle
//   gnt_valid  high exactly when gnt is non-zero
//   timeout    one-cycle pulse on a forced release
module priority_arbiter #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] gnt_q,   gnt_d;
  logic [W-1:0] idx_q,   idx_d;
  logic         vld_q,   vld_d;
  logic         to_q,    to_d;
  logic [W-1:0] ptr_q,   ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [W-1:0] win_idx;

  // Highest set index; the later iteration overrides earlier ones.
  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] r);
    pick_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) pick_fixed = W'(i);
    end
  endfunction

  // First set index scanning p, p+1, ..., wrapping modulo N.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] r,
                                           input logic [W-1:0] p);
    logic found;
    int   j;
    pick_rr = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) + i;
      if (j >= N) j = j - N;
      if (!found && r[j]) begin
        pick_rr = W'(j);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    win_idx = mode ? pick_rr(req, ptr_q) : pick_fixed(req);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        idx_d  = '0;
        vld_d  = 1'b0;
        hold_d = '0;
        if (|req) begin
          state_d = S_GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          hold_d  = HW'(1);
          ptr_d   = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
        end
      end
      S_GRANT: begin
        if (req[idx_q] && (hold_q < HW'(MAX_HOLD))) begin
          // Holder keeps the grant; other requests are ignored.
          hold_d = hold_q + HW'(1);
        end else begin
          // Voluntary drop or hold limit reached: release, then one idle cycle.
          state_d = S_IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          hold_d  = '0;
          to_d    = req[idx_q];
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_priority_arbiter.sv
module tb_priority_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
  localparam int W        = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: current holder (-1 = none), consecutive hold
  // cycles, rotation pointer, and whether the last edge was a forced release.
  int cur  = -1;
  int hold = 0;
  int ptr  = 0;
  bit to_e = 1'b0;

  priority_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input bit m, input int p);
    int w;
    w = -1;
    if (!m) begin
      for (int i = N - 1; i >= 0; i--) if (w < 0 && r[i]) w = i;
    end else begin
      for (int i = 0; i < N; i++) if (w < 0 && r[(p + i) % N]) w = (p + i) % N;
    end
    return w;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input bit m);
    to_e = 1'b0;
    if (cur < 0) begin
      if (r != 0) begin
        cur  = pick(r, m, ptr);
        hold = 1;
        ptr  = (cur + 1) % N;
      end
    end else if (r[cur] && hold < MAX_HOLD) begin
      hold = hold + 1;
    end else begin
      to_e = r[cur];
      cur  = -1;
      hold = 0;
    end
  endtask

  task automatic model_reset();
    cur  = -1;
    hold = 0;
    ptr  = 0;
    to_e = 1'b0;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = (cur >= 0) ? (N'(1) << cur) : '0;
    check("gnt",       32'(gnt),       32'(eg));
    check("gnt_idx",   32'(gnt_idx),   (cur >= 0) ? 32'(cur) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), (cur >= 0) ? 32'd1 : 32'd0);
    check("timeout",   32'(timeout),   32'(to_e));
    check("onehot0",   32'($onehot0(gnt)), 32'd1);
    check("gnt_at_idx", 32'(gnt[gnt_idx]), 32'(gnt_valid));
  endtask

  // Drive inputs, take one edge, advance the model, check 1 time unit later.
  task automatic cyc(input logic [N-1:0] r, input bit m);
    req  = r;
    mode = m;
    @(posedge clk);
    model_step(r, m);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_gnt",     32'(gnt),       32'd0);
    check("rst_idx",     32'(gnt_idx),   32'd0);
    check("rst_valid",   32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    int exp_seq;
    rst  = 1'b1;
    req  = '0;
    mode = 1'b0;
    #12;
    check("por_gnt",   32'(gnt),       32'd0);
    check("por_valid", 32'(gnt_valid), 32'd0);
    check("por_to",    32'(timeout),   32'd0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Idle: no requests for 10 cycles.
    for (int i = 0; i < 10; i++) cyc('0, i[0]);

    // Fixed priority: highest index wins and is held.
    cyc(8'b0010_0110, 1'b0);
    check("fixed_gnt", 32'(gnt), 32'h20);
    check("fixed_idx", 32'(gnt_idx), 32'd5);
    cyc(8'b0010_0110, 1'b1);
    check("fixed_hold", 32'(gnt_idx), 32'd5);
    cyc(8'b0000_0000, 1'b0);
    cyc(8'b0000_0000, 1'b0);

    // Release to another requester with one turnaround cycle.
    cyc(8'b0000_0100, 1'b0);
    check("rel_first", 32'(gnt_idx), 32'd2);
    cyc(8'b0100_0000, 1'b0);
    check("rel_gap", 32'(gnt_valid), 32'd0);
    cyc(8'b0100_0000, 1'b0);
    check("rel_next", 32'(gnt_idx), 32'd6);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // Forced release after MAX_HOLD cycles, then re-grant to the same channel.
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc(8'h80, 1'b0);
      check("to_hold", 32'(gnt_idx), 32'd7);
    end
    cyc(8'h80, 1'b0);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_gap",   32'(gnt_valid), 32'd0);
    cyc(8'h80, 1'b0);
    check("to_regrant", 32'(gnt_idx), 32'd7);
    check("to_clear",   32'(timeout), 32'd0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // Round-robin sweep from pointer 0 with wrap.
    async_reset();
    cyc(8'hFF, 1'b1);
    for (int k = 0; k <= N; k++) begin
      exp_seq = k % N;
      check("rr_seq", 32'(gnt_idx), 32'(exp_seq));
      cyc(8'hFF & ~(8'h01 << exp_seq), 1'b1);
      check("rr_gap", 32'(gnt_valid), 32'd0);
      cyc(8'hFF, 1'b1);
    end

    // Reset mid-grant; round-robin restarts from pointer 0.
    cyc(8'hFF, 1'b1);
    check("mid_valid", 32'(gnt_valid), 32'd1);
    async_reset();
    cyc(8'hF0 | 8'h01, 1'b1);
    check("rr_after_rst", 32'(gnt_idx), 32'd0);
    cyc('0, 1'b1);
    cyc('0, 1'b1);

    // Randomized traffic, biased to keep the holder requesting.
    for (int i = 0; i < 600; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      if (cur >= 0 && $urandom_range(0, 9) < 8) r[cur] = 1'b1;
      cyc(r, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
